// File: rtl/alu_multicycle_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_multicycle_if
// Brief    : Request/response bundle between a client and alu_multicycle.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_multicycle_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   data_operandA;
    logic [WIDTH-1:0]   data_operandB;
    logic [4:0]         ctrl_ALUopcode;
    logic [SHAMT_W-1:0] ctrl_shiftamt;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   data_result;
    logic               isNotEqual;
    logic               isLessThan;
    logic               overflow;
    logic               exception;

    modport master (
        output in_valid, data_operandA, data_operandB, ctrl_ALUopcode,
               ctrl_shiftamt, out_ready,
        input  in_ready, out_valid, data_result, isNotEqual, isLessThan,
               overflow, exception
    );

    modport slave (
        input  in_valid, data_operandA, data_operandB, ctrl_ALUopcode,
               ctrl_shiftamt, out_ready,
        output in_ready, out_valid, data_result, isNotEqual, isLessThan,
               overflow, exception
    );
endinterface
`default_nettype wire

// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : alu_multicycle
// Brief    : Handshaked ALU; single-cycle logic ops, iterative MUL/DIV.
// Revision : 1.0 - initial release
// ============================================================================
module alu_multicycle #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  wire logic        clock,
    input  wire logic        reset_n,
    alu_multicycle_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] c_OP_ADD = 5'd0;
    localparam logic [4:0] c_OP_SUB = 5'd1;
    localparam logic [4:0] c_OP_AND = 5'd2;
    localparam logic [4:0] c_OP_OR  = 5'd3;
    localparam logic [4:0] c_OP_SLL = 5'd4;
    localparam logic [4:0] c_OP_SRA = 5'd5;
    localparam logic [4:0] c_OP_MUL = 5'd6;
    localparam logic [4:0] c_OP_DIV = 5'd7;

    localparam int              c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   c_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_long;
    logic                   w_last;
    logic [WIDTH-1:0]       w_a;
    logic [WIDTH-1:0]       w_b;
    logic [4:0]             w_op;
    logic [WIDTH-1:0]       w_sum;
    logic [WIDTH-1:0]       w_diff;
    logic [WIDTH-1:0]       w_mag_a;
    logic [WIDTH-1:0]       w_mag_b;
    logic [WIDTH-1:0]       w_fast_res;
    logic                   w_fast_ovf;
    logic                   w_fast_exc;

    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic                   r_is_div;
    logic                   r_neg;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]     r_acc;
    logic [2*WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic [WIDTH-1:0]       r_rem;
    logic [WIDTH-1:0]       r_quo;
    logic [WIDTH-1:0]       r_dvs;

    logic [2*WIDTH-1:0]     w_acc_step;
    logic [WIDTH:0]         w_shift;
    logic [WIDTH:0]         w_sub;
    logic                   w_fits;
    logic [WIDTH-1:0]       w_rem_step;
    logic [WIDTH-1:0]       w_quo_step;
    logic [2*WIDTH-1:0]     w_prod;
    logic                   w_mul_ovf;
    logic [WIDTH-1:0]       w_quot;
    logic                   w_div0;
    logic                   w_div_ovf;

    logic [WIDTH-1:0]       r_result;
    logic                   r_ne;
    logic                   r_lt;
    logic                   r_ovf;
    logic                   r_exc;

    assign w_a    = bus.data_operandA;
    assign w_b    = bus.data_operandB;
    assign w_op   = bus.ctrl_ALUopcode;
    assign w_long = (w_op == c_OP_MUL) || (w_op == c_OP_DIV);
    assign w_last = (r_cnt == c_LAST);

    assign w_in_ready = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A DONE-state accept behaves exactly like an IDLE accept.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = w_long ? BUSY : DONE;
            end
            BUSY: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                if (w_accept)           w_state_nxt = w_long ? BUSY : DONE;
                else if (bus.out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_sum   = w_a + w_b;
    assign w_diff  = w_a - w_b;
    assign w_mag_a = w_a[WIDTH-1] ? (~w_a + 1'b1) : w_a;
    assign w_mag_b = w_b[WIDTH-1] ? (~w_b + 1'b1) : w_b;

    always_comb begin
        w_fast_res = '0;
        w_fast_ovf = 1'b0;
        w_fast_exc = 1'b0;
        case (w_op)
            c_OP_ADD: begin
                w_fast_res = w_sum;
                w_fast_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_fast_res = w_diff;
                w_fast_ovf = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
            end
            c_OP_AND: w_fast_res = w_a & w_b;
            c_OP_OR:  w_fast_res = w_a | w_b;
            c_OP_SLL: w_fast_res = w_a << bus.ctrl_shiftamt;
            c_OP_SRA: w_fast_res = $unsigned($signed(w_a) >>> bus.ctrl_shiftamt);
            c_OP_MUL,
            c_OP_DIV: w_fast_exc = 1'b0;
            default:  w_fast_exc = 1'b1;
        endcase
    end

    // One multiply bit and one restoring-divide bit per BUSY cycle, on magnitudes.
    assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_sub      = w_shift - {1'b0, r_dvs};
    assign w_fits     = (w_shift >= {1'b0, r_dvs});
    assign w_rem_step = WIDTH'(w_fits ? w_sub : w_shift);
    assign w_quo_step = {r_quo[WIDTH-2:0], w_fits};

    assign w_prod    = r_neg ? (~w_acc_step + 1'b1) : w_acc_step;
    assign w_mul_ovf = ~((&w_prod[2*WIDTH-1:WIDTH-1]) | ~(|w_prod[2*WIDTH-1:WIDTH-1]));
    assign w_quot    = r_neg ? (~w_quo_step + 1'b1) : w_quo_step;
    assign w_div0    = (r_b == '0);
    assign w_div_ovf = (r_a == c_MIN) && (&r_b);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_result <= '0;
            r_ne     <= 1'b0;
            r_lt     <= 1'b0;
            r_ovf    <= 1'b0;
            r_exc    <= 1'b0;
        end else if (w_accept) begin
            r_a      <= w_a;
            r_b      <= w_b;
            r_is_div <= (w_op == c_OP_DIV);
            r_neg    <= w_a[WIDTH-1] ^ w_b[WIDTH-1];
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_rem    <= '0;
            r_quo    <= w_mag_a;
            r_dvs    <= w_mag_b;
            // Long ops leave the visible outputs untouched until they finish.
            if (!w_long) begin
                r_result <= w_fast_res;
                r_ovf    <= w_fast_ovf;
                r_exc    <= w_fast_exc;
                r_ne     <= (w_a != w_b);
                r_lt     <= ($signed(w_a) < $signed(w_b));
            end
        end else if (r_state == BUSY) begin
            r_cnt    <= r_cnt + 1'b1;
            r_acc    <= w_acc_step;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_rem    <= w_rem_step;
            r_quo    <= w_quo_step;
            if (w_last) begin
                r_ne <= (r_a != r_b);
                r_lt <= ($signed(r_a) < $signed(r_b));
                if (r_is_div) begin
                    r_result <= w_div0 ? '0 : w_quot;
                    r_ovf    <= w_div_ovf && !w_div0;
                    r_exc    <= w_div0;
                end else begin
                    r_result <= w_prod[WIDTH-1:0];
                    r_ovf    <= w_mul_ovf;
                    r_exc    <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = (r_state == DONE);
    assign bus.data_result = r_result;
    assign bus.isNotEqual  = r_ne;
    assign bus.isLessThan  = r_lt;
    assign bus.overflow    = r_ovf;
    assign bus.exception   = r_exc;

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_multicycle
// Brief    : Directed self-checking bench for alu_multicycle (WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_multicycle;
    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_SLL = 5'd4;
    localparam logic [4:0] OP_SRA = 5'd5;
    localparam logic [4:0] OP_MUL = 5'd6;
    localparam logic [4:0] OP_DIV = 5'd7;

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    alu_multicycle_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

    alu_multicycle #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] res;
        logic        ne;
        logic        lt;
        logic        ovf;
        logic        exc;
    } resp_t;

    typedef struct {
        resp_t r;
        int    due;
    } pend_t;

    pend_t q[$];
    resp_t last_out;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour from plain signed arithmetic.
    function automatic resp_t model(input logic [4:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [4:0] sh);
        resp_t  r;
        longint sa, sb, v;
        sa = $signed(a);
        sb = $signed(b);
        r = '0;
        r.ne = (a != b);
        r.lt = (sa < sb);
        case (op)
            OP_ADD: begin v = sa + sb; r.res = v[31:0]; r.ovf = (v > MAXV) || (v < MINV); end
            OP_SUB: begin v = sa - sb; r.res = v[31:0]; r.ovf = (v > MAXV) || (v < MINV); end
            OP_AND: r.res = a & b;
            OP_OR:  r.res = a | b;
            OP_SLL: r.res = a << sh;
            OP_SRA: r.res = $unsigned($signed(a) >>> sh);
            OP_MUL: begin v = sa * sb; r.res = v[31:0]; r.ovf = (v > MAXV) || (v < MINV); end
            OP_DIV: begin
                if (b == 32'd0) begin
                    r.exc = 1'b1;
                end else if (sa == MINV && sb == -64'sd1) begin
                    r.res = a;
                    r.ovf = 1'b1;
                end else begin
                    v = sa / sb;
                    r.res = v[31:0];
                end
            end
            default: r.exc = 1'b1;
        endcase
        return r;
    endfunction

    function automatic int latency(input logic [4:0] op);
        return (op == OP_MUL || op == OP_DIV) ? WIDTH + 1 : 1;
    endfunction

    // Cycle-by-cycle comparison against the model's pending transaction.
    always @(negedge clock) begin
        if (!reset_n) begin
            q.delete();
            last_out = '0;
        end else begin
            logic  exp_ov;
            logic  exp_ir;
            resp_t act;
            pend_t p;
            act = {bus.data_result, bus.isNotEqual, bus.isLessThan, bus.overflow, bus.exception};
            exp_ov = 1'b0;
            if (q.size() > 0) exp_ov = (cyc >= q[0].due);
            exp_ir = (q.size() == 0) || (exp_ov && bus.out_ready);
            chk("out_valid", bus.out_valid, exp_ov);
            chk("in_ready", bus.in_ready, exp_ir);
            if (exp_ov) chk("result_flags", act, q[0].r);
            else        chk("held_outputs", act, last_out);
            if (exp_ov && bus.out_ready) begin
                last_out = q[0].r;
                void'(q.pop_front());
            end
            if (bus.in_valid && exp_ir) begin
                p.r   = model(bus.ctrl_ALUopcode, bus.data_operandA, bus.data_operandB, bus.ctrl_shiftamt);
                p.due = cyc + latency(bus.ctrl_ALUopcode);
                q.push_back(p);
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        bit took;
        took = 1'b0;
        bus.in_valid       = 1'b1;
        bus.ctrl_ALUopcode = op;
        bus.data_operandA  = a;
        bus.data_operandB  = b;
        bus.ctrl_shiftamt  = sh;
        for (int i = 0; i < 100 && !took; i++) begin
            @(negedge clock);
            took = bus.in_ready;
        end
        if (!took) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: got in_ready=0, want 1 within 100 cycles");
        end
        @(posedge clock);
        #1;
        // Scramble inputs so a design that fails to capture them shows up.
        bus.in_valid       = 1'b0;
        bus.ctrl_ALUopcode = 5'($urandom);
        bus.data_operandA  = $urandom;
        bus.data_operandB  = $urandom;
        bus.ctrl_shiftamt  = 5'($urandom);
    endtask

    task automatic expect_lit(input string name, input logic [31:0] res, input logic ne,
                              input logic lt, input logic ovf, input logic exc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clock);
            seen = bus.out_valid;
        end
        chk({name, "_valid"}, seen, 1'b1);
        if (seen)
            chk(name, {bus.data_result, bus.isNotEqual, bus.isLessThan, bus.overflow, bus.exception},
                {res, ne, lt, ovf, exc});
    endtask

    task automatic run(input string name, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, input logic [31:0] res,
                       input logic ne, input logic lt, input logic ovf, input logic exc);
        issue(op, a, b, sh);
        expect_lit(name, res, ne, lt, ovf, exc);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid       = 1'b0;
        bus.out_ready      = 1'b1;
        bus.ctrl_ALUopcode = '0;
        bus.data_operandA  = '0;
        bus.data_operandB  = '0;
        bus.ctrl_shiftamt  = '0;

        #1 reset_n = 1'b0;
        #2;
        chk("reset_out_valid", bus.out_valid, 1'b0);
        chk("reset_outputs", {bus.data_result, bus.isNotEqual, bus.isLessThan, bus.overflow, bus.exception}, '0);
        chk("reset_in_ready", bus.in_ready, 1'b1);
        #9 reset_n = 1'b1;
        @(negedge clock);
        chk("in_ready_after_reset", bus.in_ready, 1'b1);
        @(posedge clock);
        #1;

        //            name         op      A             B             sh     result        ne lt ov ex
        run("add_ovf",  OP_ADD, 32'h40000000, 32'h40000000, 5'd0,  32'h80000000, 0, 0, 1, 0);
        run("sub_ovf",  OP_SUB, 32'h80000001, 32'h7FFFFFFF, 5'd0,  32'h00000002, 1, 1, 1, 0);
        run("and",      OP_AND, 32'hF0F01234, 32'h0FF0FF00, 5'd9,  32'h00F01200, 1, 1, 0, 0);
        run("or",       OP_OR,  32'h12000034, 32'h00005600, 5'd3,  32'h12005634, 1, 0, 0, 0);
        run("sra4",     OP_SRA, 32'h80000010, 32'h80000010, 5'd4,  32'hF8000001, 0, 0, 0, 0);
        run("sra0",     OP_SRA, 32'h12345678, 32'h00000000, 5'd0,  32'h12345678, 1, 0, 0, 0);
        run("unsup",    5'h1F,  32'h00000003, 32'h00000003, 5'd0,  32'h00000000, 0, 0, 0, 1);
        run("mul_neg",  OP_MUL, 32'hFFFFFFFD, 32'h00000007, 5'd0,  32'hFFFFFFEB, 1, 1, 0, 0);
        run("mul_ovf",  OP_MUL, 32'h00010000, 32'h00010000, 5'd0,  32'h00000000, 0, 0, 1, 0);
        run("mul_mm1",  OP_MUL, 32'h80000000, 32'hFFFFFFFF, 5'd0,  32'h80000000, 1, 1, 1, 0);
        run("mul_m1m1", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  32'h00000001, 0, 0, 0, 0);
        run("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'h00000002, 5'd0,  32'hFFFFFFFD, 1, 1, 0, 0);
        run("div_zero", OP_DIV, 32'h00000005, 32'h00000000, 5'd0,  32'h00000000, 1, 0, 0, 1);
        run("div_mm1",  OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd0,  32'h80000000, 1, 1, 1, 0);

        // Model-only vectors, issued back-to-back where the design allows.
        issue(OP_ADD, 32'h80000000, 32'h80000000, 5'd0);
        issue(OP_SUB, 32'h00000005, 32'h00000005, 5'd0);
        issue(OP_SLL, 32'h0000000F, 32'h12345678, 5'd4);
        issue(OP_SRA, 32'h7FFFFFF0, 32'h00000001, 5'd31);
        issue(5'b01000, 32'hDEADBEEF, 32'h00000001, 5'd2);
        issue(OP_DIV, 32'h00000007, 32'hFFFFFFFE, 5'd0);
        issue(OP_DIV, 32'h80000000, 32'h00000002, 5'd0);
        issue(OP_MUL, 32'h0001E240, 32'hFFFF8000, 5'd0);
        issue(OP_ADD, 32'h7FFFFFFF, 32'h00000001, 5'd0);
        repeat (40) @(negedge clock);

        // Consumer stalls in DONE, then consumes while a new request is accepted.
        @(posedge clock);
        #1 bus.out_ready = 1'b0;
        issue(OP_ADD, 32'h7FFFFFFF, 32'h00000002, 5'd0);
        expect_lit("stall_add", 32'h80000001, 1, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("stall_in_ready", bus.in_ready, 1'b0);
            chk("stall_outputs", {bus.out_valid, bus.data_result, bus.overflow}, {1'b1, 32'h80000001, 1'b1});
        end
        @(posedge clock);
        #1;
        bus.out_ready      = 1'b1;
        bus.in_valid       = 1'b1;
        bus.ctrl_ALUopcode = OP_SLL;
        bus.data_operandA  = 32'h00000001;
        bus.data_operandB  = 32'h00000055;
        bus.ctrl_shiftamt  = 5'd31;
        @(negedge clock);
        chk("b2b_in_ready", bus.in_ready, 1'b1);
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
        @(negedge clock);
        chk("b2b_result", {bus.out_valid, bus.data_result, bus.overflow}, {1'b1, 32'h80000000, 1'b0});
        @(posedge clock);
        #1;

        // Reset in the middle of a divide abandons it.
        issue(OP_DIV, 32'd100, 32'd7, 5'd0);
        repeat (10) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        chk("midreset_out_valid", bus.out_valid, 1'b0);
        chk("midreset_outputs", {bus.data_result, bus.isNotEqual, bus.isLessThan, bus.overflow, bus.exception}, '0);
        repeat (2) @(negedge clock);
        @(posedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
        chk("in_ready_after_midreset", bus.in_ready, 1'b1);
        repeat (40) @(negedge clock);
        @(posedge clock);
        #1;
        run("add_post_reset", OP_ADD, 32'h00000001, 32'h00000010, 5'd0, 32'h00000011, 1, 1, 0, 0);
        repeat (5) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter SHAMT_W, default 5, shift-amount width; SHALL equal log2(WIDTH).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operation request present.
REQ-006 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-007 SHALL have port data_operandA  input  WIDTH  operand A, two's complement.
REQ-008 SHALL have port data_operandB  input  WIDTH  operand B, two's complement.
REQ-009 SHALL have port ctrl_ALUopcode  input  5  operation select.
REQ-010 SHALL have port ctrl_shiftamt  input  SHAMT_W  shift amount for SLL/SRA.
REQ-011 SHALL have port out_valid  output  1  result held and valid.
REQ-012 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-013 SHALL have port data_result  output  WIDTH  registered result.
REQ-014 SHALL have ports isNotEqual, isLessThan, overflow, exception  output  1 each  registered status flags.

Function
REQ-015 Opcodes SHALL be: 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 SLL, 00101 SRA, 00110 MUL, 00111 DIV; all others unsupported.
REQ-016 Acceptance SHALL occur on a rising edge where in_valid and in_ready are both 1; operands, opcode and shift amount SHALL be captured at that edge and later input changes ignored.
REQ-017 State machine SHALL have states IDLE, BUSY, DONE; reset state IDLE.
REQ-018 in_ready SHALL be 1 in IDLE, 1 in DONE only while out_ready=1, 0 in BUSY.
REQ-019 IDLE: accept of ADD/SUB/AND/OR/SLL/SRA/unsupported -> DONE (latency 1: out_valid high after the accepting edge); accept of MUL/DIV -> BUSY.
REQ-020 BUSY SHALL iterate exactly WIDTH cycles (one bit per cycle, shift-add multiply, restoring divide on magnitudes) then -> DONE; out_valid rises WIDTH+1 edges after acceptance.
REQ-021 DONE: out_valid=1; data_result and flags SHALL stay stable until out_ready=1; on out_ready=1 with no accept -> IDLE; with simultaneous accept -> behave as IDLE accept (back-to-back, no bubble).
REQ-022 ADD/SUB SHALL wrap modulo 2^WIDTH; overflow=1 on signed overflow.
REQ-023 SLL SHALL shift zeros in; SRA SHALL replicate A[WIDTH-1]; shift by 0 returns A; B ignored.
REQ-024 MUL SHALL return low WIDTH bits of the signed product; overflow=1 when the full signed product does not fit in WIDTH bits.
REQ-025 DIV SHALL return signed quotient truncated toward zero; MIN/-1 returns MIN with overflow=1; B=0 returns 0 with exception=1 and still takes WIDTH+1 cycles.
REQ-026 isNotEqual SHALL be (A != B); isLessThan SHALL be signed A < B, correct even when A-B overflows; both computed for every opcode.
REQ-027 Unsupported opcode SHALL return result 0, exception=1, overflow=0.
REQ-028 overflow SHALL be 0 for AND/OR/SLL/SRA; exception SHALL be 0 except REQ-025/REQ-027 cases.
REQ-029 While out_valid=0, data_result and flags SHALL hold their last values (no X).

Reset
REQ-030 reset_n=0 SHALL immediately force state IDLE, out_valid=0, data_result=0, all flags 0, iteration counter 0, regardless of clock.
REQ-031 reset_n asserted mid-BUSY SHALL abandon the operation; no result for it SHALL ever appear.
REQ-032 in_ready SHALL be 1 on the first rising edge after reset_n returns to 1.

Verification (WIDTH=32)
REQ-033 ADD A=0x40000000 B=0x40000000 -> result 0x80000000, overflow=1, out_valid one cycle after accept.
REQ-034 SUB A=0x80000001 B=0x7FFFFFFF -> result 0x00000002, overflow=1, isLessThan=1, isNotEqual=1.
REQ-035 MUL A=0xFFFFFFFD B=0x00000007 -> result 0xFFFFFFEB, overflow=0; in_ready=0 throughout BUSY; out_valid exactly 33 edges after accept; MUL 0x00010000*0x00010000 -> result 0, overflow=1.
REQ-036 DIV -7/2 -> 0xFFFFFFFD; DIV 5/0 -> result 0, exception=1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, overflow=1.
REQ-037 Hold out_ready=0 for 5 cycles in DONE -> result/flags stable, in_ready=0; then out_ready=1 with in_valid=1 SLL A=1 shamt=31 -> accepted same edge, next result 0x80000000.
REQ-038 Assert reset_n=0 mid-DIV between edges -> out_valid=0 and outputs 0 immediately; after release, ADD 1+0x10 -> 0x00000011 with no stale result.
